// File: rtl/uart_apu_cmd.sv
// uart_apu_cmd: 8N1 UART receiver feeding a nibble-pair command decoder.
// Bank-select bytes (1xxx_xbbb) choose a bank of 4 registers; data bytes
// (0rrh_dddd) deliver a low nibble then a high nibble for register rr,
// and the completed pair becomes a single-cycle register write.
module uart_apu_cmd #(
  parameter int unsigned CLK_HZ = 12_000_000,
  parameter int unsigned BAUD   = 9600,
  parameter int unsigned DIV    = CLK_HZ / BAUD
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic       wr_en,
  output logic [4:0] wr_addr,
  output logic [7:0] wr_data,
  output logic [2:0] bank,
  output logic       rx_err,
  output logic       cmd_err
);

  localparam int unsigned CW = $clog2(DIV);
  localparam logic [CW-1:0] CNT_MID = CW'(DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_END = CW'(DIV - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } state_t;

  state_t        state, state_next;
  logic          rx_meta, rxs;
  logic [CW-1:0] cnt;
  logic [2:0]    bitn;
  logic [7:0]    shift;
  logic          mid_hit, end_hit;
  logic          cnt_clr, shift_en, byte_valid, frame_err;
  logic [3:0]    lo;
  logic [1:0]    lo_reg;
  logic          pending;

  // Two-flop synchronizer; resets to the idle line level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  // Receiver state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  assign mid_hit = (cnt == CNT_MID);
  assign end_hit = (cnt == CNT_END);

  // Receiver next-state logic.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:      if (!rxs) state_next = START;
      START:     if (mid_hit) state_next = rxs ? IDLE : DATA;
      DATA:      if (end_hit && bitn == 3'd7) state_next = STOP;
      STOP:      if (end_hit) state_next = rxs ? IDLE : WAIT_HIGH;
      WAIT_HIGH: if (rxs) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Receiver control strobes decoded from state and bit timer.
  always_comb begin
    cnt_clr    = 1'b0;
    shift_en   = 1'b0;
    byte_valid = 1'b0;
    frame_err  = 1'b0;
    unique case (state)
      IDLE, WAIT_HIGH: cnt_clr = 1'b1;
      START:           cnt_clr = mid_hit;
      DATA: begin
        cnt_clr  = end_hit;
        shift_en = end_hit;
      end
      STOP: begin
        cnt_clr    = end_hit;
        byte_valid = end_hit && rxs;
        frame_err  = end_hit && !rxs;
      end
      default: cnt_clr = 1'b1;
    endcase
  end

  // Bit timer, data-bit index and LSB-first shift register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      bitn  <= '0;
      shift <= '0;
    end else begin
      cnt <= cnt_clr ? '0 : cnt + CW'(1);
      if (state != DATA) bitn <= '0;
      else if (shift_en) bitn <= bitn + 3'd1;
      if (shift_en) shift <= {rxs, shift[7:1]};
    end
  end

  // Command decoder: bank select, pending low nibble, paired write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      bank    <= '0;
      rx_err  <= 1'b0;
      cmd_err <= 1'b0;
      lo      <= '0;
      lo_reg  <= '0;
      pending <= 1'b0;
    end else begin
      wr_en   <= 1'b0;
      cmd_err <= 1'b0;
      rx_err  <= frame_err;
      if (byte_valid) begin
        if (shift[7]) begin
          bank    <= shift[2:0];
          pending <= 1'b0;
        end else if (!shift[4]) begin
          lo      <= shift[3:0];
          lo_reg  <= shift[6:5];
          pending <= 1'b1;
        end else if (pending && lo_reg == shift[6:5]) begin
          wr_en   <= 1'b1;
          wr_addr <= {bank, shift[6:5]};
          wr_data <= {shift[3:0], lo};
          pending <= 1'b0;
        end else begin
          cmd_err <= 1'b1;
          pending <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_uart_apu_cmd.sv
// Scoreboard bench for uart_apu_cmd: directed UART byte sequences push
// expected write / cmd_err / rx_err events; a monitor pops and compares.
module tb_uart_apu_cmd;

  localparam int unsigned CLK_HZ = 1_600_000;
  localparam int unsigned BAUD   = 100_000;
  localparam int unsigned DIV    = CLK_HZ / BAUD;

  localparam int K_WR  = 0;
  localparam int K_CMD = 1;
  localparam int K_RX  = 2;

  typedef struct {
    int       kind;
    bit [4:0] addr;
    bit [7:0] data;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       wr_en;
  logic [4:0] wr_addr;
  logic [7:0] wr_data;
  logic [2:0] bank;
  logic       rx_err;
  logic       cmd_err;

  int compared   = 0;
  int mismatched = 0;
  ev_t exp_q[$];

  uart_apu_cmd #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
    .clk    (clk),
    .rst    (rst),
    .rx     (rx),
    .wr_en  (wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .bank   (bank),
    .rx_err (rx_err),
    .cmd_err(cmd_err)
  );

  always #5 clk = ~clk;

  // Monitor: every strobe must match the oldest expected event.
  always @(negedge clk) begin
    if (!rst && (wr_en || cmd_err || rx_err)) begin
      int  k;
      ev_t e;
      k = wr_en ? K_WR : (cmd_err ? K_CMD : K_RX);
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_event: got kind=%0d addr=%0d data=%02h, expected nothing",
                 k, wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if (k != e.kind || (k == K_WR && (wr_addr != e.addr || wr_data != e.data))) begin
          mismatched++;
          $display("FAIL event: got kind=%0d addr=%0d data=%02h, expected kind=%0d addr=%0d data=%02h",
                   k, wr_addr, wr_data, e.kind, e.addr, e.data);
        end
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic push(input int kind, input int addr, input int data);
    ev_t e;
    e.kind = kind;
    e.addr = 5'(addr);
    e.data = 8'(data);
    exp_q.push_back(e);
  endtask

  task automatic bit_time(input logic v, input int unsigned n);
    rx = v;
    repeat (n * DIV) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    bit_time(1'b0, 1);
    for (int i = 0; i < 8; i++) bit_time(b[i], 1);
    bit_time(1'b1, 1);
  endtask

  task automatic drained(input string name);
    int unsigned n = 0;
    while (exp_q.size() != 0 && n < 4 * DIV) begin
      @(negedge clk);
      n++;
    end
    repeat (2 * DIV) @(negedge clk);
    check(name, exp_q.size(), 0);
  endtask

  initial begin
    logic [7:0] b27;
    b27 = 8'h27;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_bank", bank, 0);
    check("rst_errs", {rx_err, cmd_err}, 0);
    rst = 1'b0;
    repeat (2 * DIV) @(negedge clk);

    // Basic pair in bank 0
    send_byte(8'h80);
    push(K_WR, 1, 8'hA7);
    send_byte(8'h27);
    send_byte(8'h3A);
    drained("t1_drain");
    check("t1_bank", bank, 0);

    // Bank 1, three back-to-back pairs
    push(K_WR, 4, 8'h82);
    push(K_WR, 6, 8'h7C);
    push(K_WR, 7, 8'h09);
    send_byte(8'h81);
    send_byte(8'h02);
    send_byte(8'h18);
    send_byte(8'h4C);
    send_byte(8'h57);
    send_byte(8'h69);
    send_byte(8'h70);
    drained("t2_drain");
    check("t2_bank", bank, 1);

    // Orphan high nibble, then mismatched register
    push(K_CMD, 0, 0);
    push(K_CMD, 0, 0);
    send_byte(8'h3A);
    send_byte(8'h27);
    send_byte(8'h5A);
    drained("t3_drain");
    check("t3_hold_addr", wr_addr, 7);
    check("t3_hold_data", wr_data, 8'h09);

    // Framing error with break, then a valid pair in bank 1
    push(K_RX, 0, 0);
    push(K_WR, 5, 8'hCB);
    @(negedge clk);
    bit_time(1'b0, 1);
    for (int i = 0; i < 8; i++) bit_time(1'b1, 1);
    bit_time(1'b0, 3);
    bit_time(1'b1, 2);
    send_byte(8'h2B);
    send_byte(8'h3C);
    drained("t4_drain");

    // Short glitch: no effect
    @(negedge clk);
    rx = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    rx = 1'b1;
    drained("t5_glitch_drain");
    check("t5_glitch_bank", bank, 1);

    // Reset in the middle of the data bits of 0x27
    @(negedge clk);
    bit_time(1'b0, 1);
    for (int i = 0; i < 4; i++) bit_time(b27[i], 1);
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    check("t5_rst_bank", bank, 0);
    check("t5_rst_wr_en", wr_en, 0);
    rst = 1'b0;
    repeat (2 * DIV) @(negedge clk);
    push(K_WR, 1, 8'hA7);
    send_byte(8'h27);
    send_byte(8'h3A);
    drained("t5_drain");

    // Bank select clears pending low nibble
    push(K_CMD, 0, 0);
    send_byte(8'h02);
    send_byte(8'h83);
    send_byte(8'h18);
    drained("t6_drain");
    check("t6_bank", bank, 3);
    check("t6_hold_data", wr_data, 8'hA7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global watchdog.
  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/uart_apu_cmd.md
Name: uart_apu_cmd

Overview:
- Front end of the sound-chip FPGA/ASIC top; sits between the host serial pin `rx` and the APU register file.
- Receives 8N1 UART bytes and decodes the nibble-pair command protocol into single-cycle APU register writes.
- Command bytes:
  - Bank-select byte 1xxx_xbbb selects one of 8 banks of 4 registers.
  - Data byte 0rrh_dddd carries one nibble `dddd` for register `rr`; `h` = 0 for the low nibble, 1 for the high nibble.

Parameters:
- CLK_HZ, 12_000_000, system clock frequency in Hz
- BAUD, 9600, UART bit rate
- DIV, CLK_HZ/BAUD (1250), clocks per bit; must be ≥ 16

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- rx  in  1  UART serial input, idle high, asynchronous to clk
- wr_en  out  1  one-cycle register write strobe
- wr_addr  out  5  register address = {bank[2:0], rr[1:0]}
- wr_data  out  8  register data = {high nibble, low nibble}
- bank  out  3  currently selected bank
- rx_err  out  1  one-cycle pulse on framing error (stop bit sampled low)
- cmd_err  out  1  one-cycle pulse when a high nibble arrives with no matching pending low nibble

Behaviour:
- Reset values:
  - All outputs are 0.
  - FSM is IDLE, pending-nibble valid is 0, bank is 0, and both synchronizer flops are 1.
- rx input conditioning:
  - rx passes through a 2-flop synchronizer, reset to 1.
  - All logic uses the synchronized value rxs.
- Receiver FSM states: IDLE, START, DATA, STOP, WAIT_HIGH. The bit counter runs 0..DIV-1.
  - IDLE: when rxs = 0, go to START and clear the counter.
  - START: at count DIV/2-1 (mid start bit), sample rxs.
    - If rxs = 1, it was a glitch: return to IDLE with no output.
    - Otherwise clear the counter and go to DATA.
  - DATA: at count DIV-1, sample rxs into shift[7] and shift right (LSB first). After 8 samples go to STOP.
  - STOP: at count DIV-1, sample rxs.
    - If rxs = 1, assert byte_valid internally for one cycle and go to IDLE.
    - If rxs = 0, pulse rx_err, discard the byte and go to WAIT_HIGH.
  - WAIT_HIGH: stay until rxs = 1, then go to IDLE. A break condition therefore produces exactly one rx_err.
- Decoder, acting on the byte_valid cycle:
  - byte[7] = 1 (bank select): bank <= byte[2:0]; clear pending; no write.
  - byte[7] = 0, h = 0 (low nibble): lo <= dddd; lo_reg <= rr; pending <= 1. A new low nibble overwrites any older pending one.
  - byte[7] = 0, h = 1 with pending and lo_reg == rr:
    - On the next clock: wr_en = 1, wr_addr = {bank, rr}, wr_data = {dddd, lo}.
    - Pending is cleared.
  - byte[7] = 0, h = 1 with no pending, or lo_reg != rr: pulse cmd_err on the next clock; no write; pending is cleared.
- Latency and strobe rules:
  - wr_en, cmd_err and rx_err are registered. wr_en and cmd_err assert exactly 1 clk after the stop-bit sample cycle.
  - wr_en is high for exactly 1 cycle.
  - wr_addr and wr_data hold their values until the next write.
- Bank changes take effect for the next completed write. A pending low nibble does not survive a bank select.
- Asserting rst mid-frame aborts the frame; no partial write is issued.
  - If rx is still low at release, the receiver treats it as a new start bit.
  - That frame then completes normally or is rejected as a glitch.
- Back-to-back frames (stop bit directly followed by the next start edge) must be received without loss; IDLE re-arms on the cycle after STOP.

Test Plan:
- Reset, then send 0x80, 0x27, 0x3A at 9600 baud -> exactly one wr_en with wr_addr=1, wr_data=0xA7; bank=0; no err pulses.
- Send 0x81, 0x02, 0x18, 0x4C, 0x57, 0x69, 0x70 -> three writes in order: (addr 4, 0x82), (6, 0x7C), (7, 0x09); wr_en count = 3.
- Send 0x3A with nothing pending, then 0x27 followed by 0x5A -> two cmd_err pulses, zero wr_en.
- Send a frame with the stop bit forced low, holding rx low for 3 bit times -> one rx_err, no wr_en; the following valid pair 0x2B, 0x3C still writes (addr bank*4+1, 0xCB).
- Pulse rx low for DIV/4 clocks -> no state change. Then assert rst during the DATA bits of 0x27, followed by a clean 0x27, 0x3A -> only the post-reset pair writes, with 0xA7.
- Send 0x02, then 0x83, then 0x18 -> bank=3 and cmd_err, because the bank select cleared the pending nibble; no write.
